// File: rtl/console_writer_pkg.sv
// Shared character-display types and default screen geometry.
// Exports CHAR_ROWS, CHAR_COLUMNS, BLANK_CHAR, ADDR_W, char_t, cw().
package CharDisplayPkg;

  localparam int CHAR_ROWS = 30;
  localparam int CHAR_COLUMNS = 80;
  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam int ADDR_W = 15;

  typedef logic [7:0] char_t;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/console_writer_cursor.sv
// ConsoleCursor: row/col counters with wrap plus the running row base.
// Ports: clk, rst_n, adv/nl/back/cr/home controls; row, col, base, next_base, col_last.
module ConsoleCursor
  import CharDisplayPkg::*;
#(
  parameter int ROWS = 30,
  parameter int COLS = 80,
  parameter int RW = 5,
  parameter int CW = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              nl,
  input  logic              back,
  input  logic              cr,
  input  logic              home,
  output logic [RW-1:0]     row,
  output logic [CW-1:0]     col,
  output logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] next_base,
  output logic              col_last
);

  logic row_last;
  logic wrap;

  assign col_last = (col == CW'(COLS - 1));
  assign row_last = (row == RW'(ROWS - 1));
  // base tracks row*COLS incrementally so no multiplier is needed
  assign next_base = row_last ? '0 : base + ADDR_W'(COLS);
  assign wrap = nl | (adv & col_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      col  <= '0;
      base <= '0;
    end else if (home) begin
      row  <= '0;
      col  <= '0;
      base <= '0;
    end else if (wrap) begin
      col  <= '0;
      row  <= row_last ? '0 : row + 1'b1;
      base <= next_base;
    end else if (adv) begin
      col <= col + 1'b1;
    end else if (back) begin
      col <= col - 1'b1;
    end else if (cr) begin
      col <= '0;
    end
  end

endmodule

// File: rtl/console_writer.sv
// console_writer: byte stream to character-memory writes with cursor control.
// Ports: i_clk, i_rst_n, i_valid/i_data/o_ready in, o_mem_* / i_mem_ready out, o_cursor_row/col. Macro: CONSOLE_WRITER_TAB_EN.
module console_writer #(
  parameter int CHAR_ROWS = CharDisplayPkg::CHAR_ROWS,
  parameter int CHAR_COLUMNS = CharDisplayPkg::CHAR_COLUMNS,
  parameter CharDisplayPkg::char_t BLANK_CHAR = CharDisplayPkg::BLANK_CHAR
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_ready,
  output logic        o_mem_valid,
  output logic [15:0] o_mem_addr,
  output logic [31:0] o_mem_w_data,
  input  logic        i_mem_ready,
  output logic [CharDisplayPkg::cw(CHAR_ROWS)-1:0]    o_cursor_row,
  output logic [CharDisplayPkg::cw(CHAR_COLUMNS)-1:0] o_cursor_col
);

  import CharDisplayPkg::*;

  localparam int RW = cw(CHAR_ROWS);
  localparam int CW = cw(CHAR_COLUMNS);
  localparam int CELLS = CHAR_ROWS * CHAR_COLUMNS;

  typedef enum logic [1:0] {
    IDLE,
    PUT,
    CLEAR_ROW,
    CLEAR_SCREEN
  } state_t;

  state_t state;
  logic ready;
  logic mem_valid;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] left;
  char_t wdata;
  logic adv_q;
  logic tab_q;

  logic accept, done;
  logic is_print, is_nl, is_cr, is_bs, is_ff, is_tab;
  logic tab_more;
  logic c_adv, c_nl, c_back, c_cr, c_home;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [ADDR_W-1:0] base, next_base;
  logic col_last;

  assign accept = i_valid & ready;
  assign done = mem_valid & i_mem_ready;

  assign is_print = (i_data >= 8'h20) && (i_data <= 8'h7e);
  assign is_nl = (i_data == 8'h0a);
  assign is_cr = (i_data == 8'h0d);
  assign is_bs = (i_data == 8'h08);
  assign is_ff = (i_data == 8'h0c);
`ifdef CONSOLE_WRITER_TAB_EN
  assign is_tab = (i_data == 8'h09);
`else
  assign is_tab = 1'b0;
`endif

  // a tab keeps blanking until the column after this write is a multiple of 8
  assign tab_more = ((int'(col) + 1) % 8) != 0;

  assign c_adv = (state == PUT) & done & adv_q;
  assign c_nl = accept & is_nl;
  assign c_back = accept & is_bs & (col != '0);
  assign c_cr = accept & is_cr;
  assign c_home = accept & is_ff;

  ConsoleCursor #(
    .ROWS(CHAR_ROWS),
    .COLS(CHAR_COLUMNS),
    .RW(RW),
    .CW(CW)
  ) u_cursor (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .adv(c_adv),
    .nl(c_nl),
    .back(c_back),
    .cr(c_cr),
    .home(c_home),
    .row(row),
    .col(col),
    .base(base),
    .next_base(next_base),
    .col_last(col_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      ready     <= 1'b0;
      mem_valid <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      left      <= '0;
      adv_q     <= 1'b0;
      tab_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ready <= 1'b1;
          if (accept) begin
            unique case (1'b1)
              is_print | is_tab: begin
                state     <= PUT;
                ready     <= 1'b0;
                mem_valid <= 1'b1;
                addr      <= base + ADDR_W'(col);
                wdata     <= is_tab ? BLANK_CHAR : i_data;
                adv_q     <= 1'b1;
                tab_q     <= is_tab;
              end
              is_bs && (col != '0): begin
                state     <= PUT;
                ready     <= 1'b0;
                mem_valid <= 1'b1;
                addr      <= base + ADDR_W'(col) - 1'b1;
                wdata     <= BLANK_CHAR;
                adv_q     <= 1'b0;
                tab_q     <= 1'b0;
              end
              is_nl: begin
                state     <= CLEAR_ROW;
                ready     <= 1'b0;
                mem_valid <= 1'b1;
                addr      <= next_base;
                wdata     <= BLANK_CHAR;
                left      <= ADDR_W'(CHAR_COLUMNS - 1);
              end
              is_ff: begin
                state     <= CLEAR_SCREEN;
                ready     <= 1'b0;
                mem_valid <= 1'b1;
                addr      <= '0;
                wdata     <= BLANK_CHAR;
                left      <= ADDR_W'(CELLS - 1);
              end
              default: ;
            endcase
          end
        end
        PUT: begin
          if (done) begin
            if (adv_q && col_last) begin
              state <= CLEAR_ROW;
              addr  <= next_base;
              wdata <= BLANK_CHAR;
              left  <= ADDR_W'(CHAR_COLUMNS - 1);
            end else if (tab_q && tab_more) begin
              addr <= addr + 1'b1;
            end else begin
              state     <= IDLE;
              mem_valid <= 1'b0;
              ready     <= 1'b1;
            end
          end
        end
        CLEAR_ROW, CLEAR_SCREEN: begin
          if (done) begin
            if (left == '0) begin
              state     <= IDLE;
              mem_valid <= 1'b0;
              ready     <= 1'b1;
            end else begin
              left <= left - 1'b1;
              addr <= addr + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign o_ready = ready;
  assign o_mem_valid = mem_valid;
  assign o_mem_addr = {1'b0, addr};
  assign o_mem_w_data = {24'h0, wdata};
  assign o_cursor_row = row;
  assign o_cursor_col = col;

endmodule
